// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: glyphs, digit count,
// page/edit-field encodings and the latched frame record.
// Pure declarations; no logic, no latency, no flow control.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    PAGE_HHMM = 1'b0,
    PAGE_MMSS = 1'b1
  } page_e;

  typedef enum logic {
    POS_MIN  = 1'b0,
    POS_HOUR = 1'b1
  } pos_e;

  // Snapshot of everything the display needs for one full scan.
  typedef struct packed {
    logic [3:0] h2;
    logic [3:0] h1;
    logic [3:0] m2;
    logic [3:0] m1;
    logic [3:0] s2;
    logic [3:0] s1;
    pos_e       pos;
    logic       edit_en;
    page_e      page;
  } frame_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment glyph; codes 10..15 render as a dash.
// Latency: purely combinational.
// Backpressure: none.
// Ports: bcd [3:0] digit in; seg [6:0] cathodes out, {g,f,e,d,c,b,a}, active low.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode driver with frame latch, guard blanking,
// edit blink and leading-zero suppression. Latency: outputs registered, 1 cycle.
// Backpressure: none; free-running scan, inputs are sampled once per frame.
// Ports: clk, rst_n (async, active low); h2..s1 BCD digits; pos (1 = hours field),
//        edit_en (blink enable), page_sel (0 = HH:MM, 1 = MM:SS);
//        an[3:0] anodes active low (an[0] rightmost), seg[6:0] {g..a} and dp, active low.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 4000,
  parameter int BLINK_HZ   = 2,
  parameter int GUARD_CYC  = 16,
  parameter bit LZ_BLANK   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            h2,
  input  logic [3:0]            h1,
  input  logic [3:0]            m2,
  input  logic [3:0]            m1,
  input  logic [3:0]            s2,
  input  logic [3:0]            s1,
  input  logic                  pos,
  input  logic                  edit_en,
  input  logic                  page_sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  // TICK_DIV must be at least 4 and larger than GUARD_CYC.
  localparam int TICK_DIV   = CLK_HZ / REFRESH_HZ;
  localparam int HALF_BLINK = CLK_HZ / (2 * BLINK_HZ);
  localparam int SLOT_W     = $clog2(TICK_DIV);
  localparam int BLINK_W    = (HALF_BLINK > 1) ? $clog2(HALF_BLINK) : 1;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(TICK_DIV - 1);
  localparam logic [SLOT_W-1:0]  GUARD_END  = SLOT_W'(GUARD_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(HALF_BLINK - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]   IDX_COLON  = IDX_W'(2);

  logic [SLOT_W-1:0]  slot_cnt;
  logic [IDX_W-1:0]   idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  frame_t             frame_q;

  logic               slot_last;
  logic               frame_last;
  logic [3:0]         digit;
  logic [6:0]         glyph;
  logic               field_hit;
  logic               blanked;
  logic               lit;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]         seg_nxt;
  logic               dp_nxt;

  assign slot_last  = (slot_cnt == SLOT_LAST);
  assign frame_last = slot_last && (idx == IDX_LAST);

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Blink half-period counter; runs independently of the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Inputs are captured only at the very end of the idx=3 slot, so a whole
  // scan always shows one coherent time value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (frame_last) begin
      frame_q.h2      <= h2;
      frame_q.h1      <= h1;
      frame_q.m2      <= m2;
      frame_q.m1      <= m1;
      frame_q.s2      <= s2;
      frame_q.s1      <= s1;
      frame_q.pos     <= pos_e'(pos);
      frame_q.edit_en <= edit_en;
      frame_q.page    <= page_e'(page_sel);
    end
  end

  always_comb begin
    digit = frame_q.m1;
    if (frame_q.page == PAGE_HHMM) begin
      case (idx)
        2'd3:    digit = frame_q.h2;
        2'd2:    digit = frame_q.h1;
        2'd1:    digit = frame_q.m2;
        default: digit = frame_q.m1;
      endcase
    end else begin
      case (idx)
        2'd3:    digit = frame_q.m2;
        2'd2:    digit = frame_q.m1;
        2'd1:    digit = frame_q.s2;
        default: digit = frame_q.s1;
      endcase
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (glyph)
  );

  // idx[MSB] selects the left pair (idx 3,2). On HH:MM the left pair is hours,
  // on MM:SS it is minutes; the hours field has no digits on MM:SS.
  always_comb begin
    field_hit = 1'b0;
    if (frame_q.page == PAGE_HHMM) begin
      field_hit = (frame_q.pos == POS_HOUR) ? idx[IDX_W-1] : !idx[IDX_W-1];
    end else begin
      field_hit = (frame_q.pos == POS_MIN) && idx[IDX_W-1];
    end
  end

  always_comb begin
    blanked = (frame_q.edit_en && blink_phase && field_hit) ||
              (LZ_BLANK && (frame_q.page == PAGE_HHMM) &&
               (idx == IDX_LAST) && (frame_q.h2 == 4'd0));
    lit     = (slot_cnt >= GUARD_END) && !blanked;
    an_nxt  = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    // The cathodes switch to the new digit while anodes are still off in the
    // guard window, so they have settled before the anode turns on.
    seg_nxt = blanked ? SEG_BLANK : glyph;
    dp_nxt  = !(lit && (idx == IDX_COLON));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with small clock parameters.
// Reference model derives expected outputs from elapsed cycles since reset.
// Directed scenarios plus randomized input sequences.
module tb_seg7_scan_driver;

  localparam int TICK_DIV   = 10;
  localparam int HALF_BLINK = 50;
  localparam int GUARD_CYC  = 2;
  localparam int FRAME      = 4 * TICK_DIV;

  localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct packed {
    logic [3:0] h2, h1, m2, m1, s2, s1;
    logic       pos, edit_en, page;
  } snap_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       known;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] h2, h1, m2, m1, s2, s1;
  logic       pos, edit_en, page_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .CLK_HZ     (1000),
    .REFRESH_HZ (100),
    .BLINK_HZ   (10),
    .GUARD_CYC  (GUARD_CYC),
    .LZ_BLANK   (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .h2       (h2),
    .h1       (h1),
    .m2       (m2),
    .m1       (m1),
    .s2       (s2),
    .s1       (s1),
    .pos      (pos),
    .edit_en  (edit_en),
    .page_sel (page_sel),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  // Model: the display at elapsed cycle s is a pure function of s and the
  // frame snapshot; the output registers delay it by one clock.
  function automatic exp_t model(int s, snap_t f);
    exp_t       r;
    int         slot, dig, phase, field, edited;
    logic [3:0] d;
    logic       blank, lit;
    slot  = s % TICK_DIV;
    dig   = (s / TICK_DIV) % 4;
    phase = (s / HALF_BLINK) % 2;
    // field codes: 2 = hours, 1 = minutes, 0 = seconds
    if (!f.page) begin
      case (dig)
        3: d = f.h2;
        2: d = f.h1;
        1: d = f.m2;
        default: d = f.m1;
      endcase
      field = (dig >= 2) ? 2 : 1;
    end else begin
      case (dig)
        3: d = f.m2;
        2: d = f.m1;
        1: d = f.s2;
        default: d = f.s1;
      endcase
      field = (dig >= 2) ? 1 : 0;
    end
    edited  = f.pos ? 2 : 1;
    blank   = (f.edit_en && phase == 1 && field == edited) ||
              (!f.page && dig == 3 && f.h2 == 4'd0);
    lit     = (slot >= GUARD_CYC) && !blank;
    r.an    = 4'hF;
    if (lit) r.an[dig[1:0]] = 1'b0;
    r.seg   = (d < 4'd10) ? GLYPH[d] : 7'h3F;
    r.dp    = !(lit && dig == 2);
    r.known = !blank;
    return r;
  endfunction

  int    cyc;
  snap_t cur_in, mdl_frame;
  exp_t  m_nxt, m_exp;

  always_comb cur_in = {h2, h1, m2, m1, s2, s1, pos, edit_en, page_sel};
  always_comb m_nxt = model(cyc, mdl_frame);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc       <= 0;
      mdl_frame <= '0;
      m_exp     <= '{an: 4'hF, seg: 7'h7F, dp: 1'b1, known: 1'b1};
    end else begin
      m_exp <= m_nxt;
      if (cyc % FRAME == FRAME - 1) mdl_frame <= cur_in;
      cyc <= cyc + 1;
    end
  end

  task automatic set_digits(input logic [3:0] a, b, c, d, e, f);
    h2 = a; h1 = b; m2 = c; m1 = d; s2 = e; s1 = f;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_digits(4'd1, 4'd2, 4'd5, 4'd8, 4'd0, 4'd0);
    page_sel = 1'b0; pos = 1'b0; edit_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (an !== 4'hF) begin miscompares++; $display("FAIL reset_an got=%b want=1111", an); end
    vectors++;
    if (seg !== 7'h7F) begin miscompares++; $display("FAIL reset_seg got=%h want=7f", seg); end
    vectors++;
    if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp got=%b want=1", dp); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan_page0();
    int lit_cnt [4] = '{0, 0, 0, 0};
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      vectors++;
      if (an !== m_exp.an || dp !== m_exp.dp || (m_exp.known && seg !== m_exp.seg)) begin
        miscompares++;
        $display("FAIL scan_p0 cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, m_exp.an, seg, m_exp.seg, dp, m_exp.dp);
      end
      if (cyc > 40) begin
        case (an)
          4'b1110: lit_cnt[0]++;
          4'b1101: lit_cnt[1]++;
          4'b1011: lit_cnt[2]++;
          4'b0111: lit_cnt[3]++;
          default: ;
        endcase
      end
      if (cyc == 6) begin
        vectors++;
        if (an !== 4'b1110 || seg !== 7'h40) begin miscompares++; $display("FAIL first_frame_zero an=%b seg=%h want 1110/40", an, seg); end
      end
      if (cyc == 36) begin
        vectors++;
        if (an !== 4'hF) begin miscompares++; $display("FAIL first_frame_lz an=%b want 1111", an); end
      end
      if (cyc == 41) begin
        vectors++;
        if (an !== 4'hF || seg !== 7'h00) begin miscompares++; $display("FAIL guard_seg an=%b seg=%h want 1111/00", an, seg); end
      end
      if (cyc == 46) begin
        vectors++;
        if (an !== 4'b1110 || seg !== 7'h00 || dp !== 1'b1) begin miscompares++; $display("FAIL p0_idx0 an=%b seg=%h dp=%b want 1110/00/1", an, seg, dp); end
      end
      if (cyc == 56) begin
        vectors++;
        if (an !== 4'b1101 || seg !== 7'h12) begin miscompares++; $display("FAIL p0_idx1 an=%b seg=%h want 1101/12", an, seg); end
      end
      if (cyc == 66) begin
        vectors++;
        if (an !== 4'b1011 || seg !== 7'h24 || dp !== 1'b0) begin miscompares++; $display("FAIL p0_idx2_colon an=%b seg=%h dp=%b want 1011/24/0", an, seg, dp); end
      end
      if (cyc == 76) begin
        vectors++;
        if (an !== 4'b0111 || seg !== 7'h79 || dp !== 1'b1) begin miscompares++; $display("FAIL p0_idx3 an=%b seg=%h dp=%b want 0111/79/1", an, seg, dp); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (lit_cnt[i] != TICK_DIV - GUARD_CYC) begin
        miscompares++;
        $display("FAIL lit_cycles digit=%0d got=%0d want=%0d", i, lit_cnt[i], TICK_DIV - GUARD_CYC);
      end
    end
  endtask

  task automatic test_tear_free();
    int fs, n_cyc;
    fs = ((cyc + FRAME - 1) / FRAME) * FRAME;
    n_cyc = fs + 80 - cyc;
    for (int n = 0; n < n_cyc; n++) begin
      @(negedge clk);
      vectors++;
      if (an !== m_exp.an || dp !== m_exp.dp || (m_exp.known && seg !== m_exp.seg)) begin
        miscompares++;
        $display("FAIL tear_model cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, m_exp.an, seg, m_exp.seg, dp, m_exp.dp);
      end
      if (cyc == fs + 15) begin
        m1 = 4'd9; h1 = 4'd3;
      end
      if (cyc == fs + 26) begin
        vectors++;
        if (an !== 4'b1011 || seg !== 7'h24) begin miscompares++; $display("FAIL tear_same_frame an=%b seg=%h want 1011/24", an, seg); end
      end
      if (cyc == fs + 46) begin
        vectors++;
        if (an !== 4'b1110 || seg !== 7'h10) begin miscompares++; $display("FAIL tear_next_m1 an=%b seg=%h want 1110/10", an, seg); end
      end
      if (cyc == fs + 66) begin
        vectors++;
        if (an !== 4'b1011 || seg !== 7'h30) begin miscompares++; $display("FAIL tear_next_h1 an=%b seg=%h want 1011/30", an, seg); end
      end
    end
  endtask

  task automatic test_page1();
    int fs, n_cyc;
    set_digits(4'd0, 4'd3, 4'd5, 4'd8, 4'd4, 4'd7);
    page_sel = 1'b1;
    fs = (cyc / FRAME + 1) * FRAME;
    n_cyc = fs + 41 - cyc;
    for (int n = 0; n < n_cyc; n++) begin
      @(negedge clk);
      vectors++;
      if (an !== m_exp.an || dp !== m_exp.dp || (m_exp.known && seg !== m_exp.seg)) begin
        miscompares++;
        $display("FAIL p1_model cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, m_exp.an, seg, m_exp.seg, dp, m_exp.dp);
      end
      if (cyc == fs + 6) begin
        vectors++;
        if (an !== 4'b1110 || seg !== 7'h78) begin miscompares++; $display("FAIL p1_idx0 an=%b seg=%h want 1110/78", an, seg); end
      end
      if (cyc == fs + 16) begin
        vectors++;
        if (an !== 4'b1101 || seg !== 7'h19) begin miscompares++; $display("FAIL p1_idx1 an=%b seg=%h want 1101/19", an, seg); end
      end
      if (cyc == fs + 26) begin
        vectors++;
        if (an !== 4'b1011 || seg !== 7'h00 || dp !== 1'b0) begin miscompares++; $display("FAIL p1_idx2 an=%b seg=%h dp=%b want 1011/00/0", an, seg, dp); end
      end
      if (cyc == fs + 36) begin
        vectors++;
        if (an !== 4'b0111 || seg !== 7'h12) begin miscompares++; $display("FAIL p1_no_lz an=%b seg=%h want 0111/12", an, seg); end
      end
    end
  endtask

  task automatic test_invalid_bcd();
    int fs, n_cyc;
    s1 = 4'hC;
    fs = (cyc / FRAME + 1) * FRAME;
    n_cyc = fs + 41 - cyc;
    for (int n = 0; n < n_cyc; n++) begin
      @(negedge clk);
      vectors++;
      if (an !== m_exp.an || dp !== m_exp.dp || (m_exp.known && seg !== m_exp.seg)) begin
        miscompares++;
        $display("FAIL bcd_model cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, m_exp.an, seg, m_exp.seg, dp, m_exp.dp);
      end
      if (cyc == fs + 6) begin
        vectors++;
        if (an !== 4'b1110 || seg !== 7'h3F) begin miscompares++; $display("FAIL bcd_dash an=%b seg=%h want 1110/3f", an, seg); end
      end
    end
  endtask

  task automatic test_blink_hours();
    int fs, n_cyc, s, hi_bad, hi_lit, lo_lit;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    page_sel = 1'b0; pos = 1'b1; edit_en = 1'b1;
    hi_bad = 0; hi_lit = 0; lo_lit = 0;
    fs = (cyc / FRAME + 1) * FRAME;
    n_cyc = fs + 201 - cyc;
    for (int n = 0; n < n_cyc; n++) begin
      @(negedge clk);
      vectors++;
      if (an !== m_exp.an || dp !== m_exp.dp || (m_exp.known && seg !== m_exp.seg)) begin
        miscompares++;
        $display("FAIL blink_model cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, m_exp.an, seg, m_exp.seg, dp, m_exp.dp);
      end
      s = cyc - 1;
      if (s >= fs) begin
        if ((s / HALF_BLINK) % 2 == 1) begin
          if (an[3:2] != 2'b11) hi_bad++;
          if (an[1:0] != 2'b11) lo_lit++;
        end else if (an[3:2] != 2'b11) begin
          hi_lit++;
        end
      end
    end
    vectors++;
    if (hi_bad != 0) begin miscompares++; $display("FAIL blink_off_window hours lit=%0d want 0", hi_bad); end
    vectors++;
    if (lo_lit == 0) begin miscompares++; $display("FAIL blink_minutes_steady lit=%0d want >0", lo_lit); end
    vectors++;
    if (hi_lit == 0) begin miscompares++; $display("FAIL blink_on_window hours lit=%0d want >0", hi_lit); end
  endtask

  task automatic test_blink_page1();
    int fs, n_cyc, s, dark;
    page_sel = 1'b1; pos = 1'b1; edit_en = 1'b1;
    dark = 0;
    fs = (cyc / FRAME + 1) * FRAME;
    n_cyc = fs + 121 - cyc;
    for (int n = 0; n < n_cyc; n++) begin
      @(negedge clk);
      vectors++;
      if (an !== m_exp.an || dp !== m_exp.dp || (m_exp.known && seg !== m_exp.seg)) begin
        miscompares++;
        $display("FAIL blink_p1_model cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, m_exp.an, seg, m_exp.seg, dp, m_exp.dp);
      end
      s = cyc - 1;
      if (s >= fs && (s % TICK_DIV) >= GUARD_CYC && an == 4'hF) dark++;
    end
    vectors++;
    if (dark != 0) begin miscompares++; $display("FAIL blink_p1_none dark_cycles=%0d want 0", dark); end
  endtask

  task automatic test_random();
    int n_cyc;
    for (int it = 0; it < 10; it++) begin
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      pos      = 1'($urandom_range(0, 1));
      edit_en  = 1'($urandom_range(0, 1));
      page_sel = 1'($urandom_range(0, 1));
      n_cyc    = $urandom_range(15, 90);
      for (int n = 0; n < n_cyc; n++) begin
        @(negedge clk);
        vectors++;
        if (an !== m_exp.an || dp !== m_exp.dp || (m_exp.known && seg !== m_exp.seg)) begin
          miscompares++;
          $display("FAIL rand_model it=%0d cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", it, cyc, an, m_exp.an, seg, m_exp.seg, dp, m_exp.dp);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int  fs;
    logic found;
    set_digits(4'd1, 4'd0, 4'd2, 4'd3, 4'd4, 4'd5);
    page_sel = 1'b0; pos = 1'b0; edit_en = 1'b0;
    fs = (cyc / FRAME + 1) * FRAME;
    found = 1'b0;
    for (int n = 0; n < 130 && !found; n++) begin
      @(negedge clk);
      vectors++;
      if (an !== m_exp.an || dp !== m_exp.dp || (m_exp.known && seg !== m_exp.seg)) begin
        miscompares++;
        $display("FAIL arst_pre_model cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, m_exp.an, seg, m_exp.seg, dp, m_exp.dp);
      end
      if (cyc == fs + 25) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL arst_wait_timeout cyc=%0d want %0d", cyc, fs + 25);
    end else if (an !== 4'b1011 || dp !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_pre_lit an=%b dp=%b want 1011/0", an, dp);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_immediate an=%b seg=%h dp=%b want 1111/7f/1", an, seg, dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      vectors++;
      if (an !== m_exp.an || dp !== m_exp.dp || (m_exp.known && seg !== m_exp.seg)) begin
        miscompares++;
        $display("FAIL arst_post_model cyc=%0d an=%b/%b seg=%h/%h dp=%b/%b", cyc, an, m_exp.an, seg, m_exp.seg, dp, m_exp.dp);
      end
      if (cyc == 6) begin
        vectors++;
        if (an !== 4'b1110 || seg !== 7'h40) begin miscompares++; $display("FAIL arst_restart_idx0 an=%b seg=%h want 1110/40", an, seg); end
      end
      if (cyc == 26) begin
        vectors++;
        if (an !== 4'b1011 || seg !== 7'h40) begin miscompares++; $display("FAIL arst_frame_zero an=%b seg=%h want 1011/40", an, seg); end
      end
      if (cyc == 36) begin
        vectors++;
        if (an !== 4'hF) begin miscompares++; $display("FAIL arst_lz_zero_frame an=%b want 1111", an); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_page0();
    test_tear_free();
    test_page1();
    test_invalid_bcd();
    test_blink_hours();
    test_blink_page1();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
